mat_sq_verify: RTL

- Checker that sits downstream of the matrix square-root engine.
- Takes a candidate root X and the original matrix A, both 3x3, signed 33-bit, Q-format with 1.0 = 64.
- Computes X·X sequentially with one shared multiply-accumulate, rescales it, and compares it element-wise against A.
- Reports the squared matrix, the worst-case absolute error and a pass flag, so root results can be checked in-system or on the bench.

---
 rtl/mat_sqrt_pkg.sv | 32 +++
 rtl/mat_sq_mac.sv | 69 ++++++
 rtl/mat_sq_verify.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mat_sqrt_pkg.sv
// mat_sqrt_pkg: shared types and constants for the matrix square-root engine
// and its downstream checker (mat_sq_verify).
//   ELEM_W : matrix element width (signed, Q-format with 1.0 = Q_ONE)
//   ACC_W  : multiply-accumulate width
//   ERR_W  : unsigned error magnitude width
package mat_sqrt_pkg;

   localparam int unsigned ELEM_W = 33;
   localparam int unsigned PROD_W = 2 * ELEM_W;
   localparam int unsigned ACC_W  = 68;
   localparam int unsigned ERR_W  = 34;
   localparam int unsigned Q_ONE  = 64;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_CMP,
      S_DONE
   } state_t;

   typedef logic signed [ELEM_W-1:0] elem_t;
   typedef elem_t mat3_t [3][3];

   // |p - q| evaluated one bit wider than the operands so that the extreme
   // difference 2^33 is still representable as an unsigned magnitude.
   function automatic logic [ERR_W-1:0] abs_diff(input elem_t p, input elem_t q);
      logic [ERR_W-1:0] d;
      d = {p[ELEM_W-1], p} - {q[ELEM_W-1], q};
      return d[ERR_W-1] ? ('0 - d) : d;
   endfunction

endpackage

// File: rtl/mat_sq_mac.sv
// mat_sq_mac: registered multiply-accumulate for one element of X*X.
//   iclk, ireset : clock, asynchronous active-low reset
//   clr          : clear the accumulator (start of a new run)
//   en           : accumulate mul_a*mul_b this cycle
//   last         : final term of the element; accumulator clears afterwards
//   mul_a, mul_b : signed operands
//   elem         : (acc + mul_a*mul_b) >>> ZOOM reduced to ELEM_W bits
//   ovf          : elem was clamped (only with MAT_SQ_VERIFY_SAT_EN)
// Build option MAT_SQ_VERIFY_SAT_EN: clamp to the ELEM_W range and flag it;
// otherwise the shifted value wraps to its low ELEM_W bits and ovf is 0.
module mat_sq_mac
   import mat_sqrt_pkg::*;
#(
   parameter int unsigned ZOOM = 6
) (
   input  logic  iclk,
   input  logic  ireset,
   input  logic  clr,
   input  logic  en,
   input  logic  last,
   input  elem_t mul_a,
   input  elem_t mul_b,
   output elem_t elem,
   output logic  ovf
);

   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  sum;
   logic signed [PROD_W-1:0] prod;

   assign prod = $signed({{ELEM_W{mul_a[ELEM_W-1]}}, mul_a})
               * $signed({{ELEM_W{mul_b[ELEM_W-1]}}, mul_b});
   assign sum  = acc + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});

`ifdef MAT_SQ_VERIFY_SAT_EN
   logic signed [ACC_W-1:0]      shifted;
   logic        [ACC_W-ELEM_W:0] hi;
   logic                         fits;

   always_comb begin
      shifted = sum >>> ZOOM;
      // in range when every bit from the element sign upward agrees
      hi      = shifted[ACC_W-1:ELEM_W-1];
      fits    = (&hi) | (~|hi);
      ovf     = ~fits;
      if (fits)
         elem = shifted[ELEM_W-1:0];
      else if (shifted[ACC_W-1])
         elem = {1'b1, {(ELEM_W-1){1'b0}}};
      else
         elem = {1'b0, {(ELEM_W-1){1'b1}}};
   end
`else
   always_comb begin
      elem = sum[ZOOM+ELEM_W-1:ZOOM];
      ovf  = 1'b0;
   end
`endif

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= last ? '0 : sum;
   end

endmodule

// File: rtl/mat_sq_verify.sv
// mat_sq_verify: checks a candidate matrix root X against A by computing
// (X*X) >>> ZOOM with one shared MAC (27 cycles), then comparing the 9
// elements against A (9 cycles) and reporting the worst absolute error.
//   iclk, ireset      : clock, asynchronous active-low reset
//   i_start           : start request, sampled only when idle
//   i_x00..i_x22      : candidate root X, row-major, signed
//   i_a00..i_a22      : reference matrix A, row-major, signed
//   o_sq00..o_sq22    : registered (X*X) >>> ZOOM
//   o_maxerr          : max |sq - a| over all elements
//   o_pass            : o_maxerr <= TOL
//   o_ovf             : an element was clamped (MAT_SQ_VERIFY_SAT_EN builds)
//   o_busy            : run in progress
//   o_Dval            : one-cycle completion pulse
// Build option MAT_SQ_VERIFY_SAT_EN selects clamping in mat_sq_mac.
module mat_sq_verify
   import mat_sqrt_pkg::*;
#(
   parameter int unsigned ZOOM = 6,
   parameter int unsigned TOL  = 2
) (
   input  logic                     iclk,
   input  logic                     ireset,
   input  logic                     i_start,
   input  logic signed [ELEM_W-1:0] i_x00, i_x01, i_x02,
   input  logic signed [ELEM_W-1:0] i_x10, i_x11, i_x12,
   input  logic signed [ELEM_W-1:0] i_x20, i_x21, i_x22,
   input  logic signed [ELEM_W-1:0] i_a00, i_a01, i_a02,
   input  logic signed [ELEM_W-1:0] i_a10, i_a11, i_a12,
   input  logic signed [ELEM_W-1:0] i_a20, i_a21, i_a22,
   output logic signed [ELEM_W-1:0] o_sq00, o_sq01, o_sq02,
   output logic signed [ELEM_W-1:0] o_sq10, o_sq11, o_sq12,
   output logic signed [ELEM_W-1:0] o_sq20, o_sq21, o_sq22,
   output logic        [ERR_W-1:0]  o_maxerr,
   output logic                     o_pass,
   output logic                     o_ovf,
   output logic                     o_busy,
   output logic                     o_Dval
);

   state_t           state, state_nx;
   mat3_t            x_in, a_in, x_l, a_l, sq_l, sq_out;
   logic [1:0]       r, c, k;
   logic [ERR_W-1:0] max_run, abs_d, max_nx;
   logic             ovf_flag;
   logic             start_go, mac_en, mac_last, mac_end, cmp_end;
   elem_t            mac_elem;
   logic             mac_ovf;

   assign x_in[0][0] = i_x00;  assign x_in[0][1] = i_x01;  assign x_in[0][2] = i_x02;
   assign x_in[1][0] = i_x10;  assign x_in[1][1] = i_x11;  assign x_in[1][2] = i_x12;
   assign x_in[2][0] = i_x20;  assign x_in[2][1] = i_x21;  assign x_in[2][2] = i_x22;
   assign a_in[0][0] = i_a00;  assign a_in[0][1] = i_a01;  assign a_in[0][2] = i_a02;
   assign a_in[1][0] = i_a10;  assign a_in[1][1] = i_a11;  assign a_in[1][2] = i_a12;
   assign a_in[2][0] = i_a20;  assign a_in[2][1] = i_a21;  assign a_in[2][2] = i_a22;

   assign o_sq00 = sq_out[0][0];  assign o_sq01 = sq_out[0][1];  assign o_sq02 = sq_out[0][2];
   assign o_sq10 = sq_out[1][0];  assign o_sq11 = sq_out[1][1];  assign o_sq12 = sq_out[1][2];
   assign o_sq20 = sq_out[2][0];  assign o_sq21 = sq_out[2][1];  assign o_sq22 = sq_out[2][2];

   assign o_busy = (state != S_IDLE);

   mat_sq_mac #(
      .ZOOM (ZOOM)
   ) u_mac (
      .iclk   (iclk),
      .ireset (ireset),
      .clr    (start_go),
      .en     (mac_en),
      .last   (mac_last),
      .mul_a  (x_l[r][k]),
      .mul_b  (x_l[k][c]),
      .elem   (mac_elem),
      .ovf    (mac_ovf)
   );

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      start_go = 1'b0;
      mac_en   = 1'b0;
      mac_last = (k == 2'd2);
      mac_end  = mac_last && (r == 2'd2) && (c == 2'd2);
      cmp_end  = (r == 2'd2) && (c == 2'd2);
      abs_d    = abs_diff(sq_l[r][c], a_l[r][c]);
      max_nx   = (abs_d > max_run) ? abs_d : max_run;
      case (state)
         S_IDLE: begin
            if (i_start) begin
               start_go = 1'b1;
               state_nx = S_MAC;
            end
         end
         S_MAC: begin
            mac_en = 1'b1;
            if (mac_end)
               state_nx = S_CMP;
         end
         S_CMP: begin
            if (cmp_end)
               state_nx = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // r/c walk the elements row-major in both MAC and CMP; they wrap to 0
   // at the end of MAC so CMP starts from element (0,0) without a reload.
   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         for (int unsigned i = 0; i < 3; i++) begin
            for (int unsigned j = 0; j < 3; j++) begin
               x_l[i][j]    <= '0;
               a_l[i][j]    <= '0;
               sq_l[i][j]   <= '0;
               sq_out[i][j] <= '0;
            end
         end
         r        <= '0;
         c        <= '0;
         k        <= '0;
         max_run  <= '0;
         ovf_flag <= 1'b0;
         o_maxerr <= '0;
         o_pass   <= 1'b0;
         o_ovf    <= 1'b0;
         o_Dval   <= 1'b0;
      end else begin
         o_Dval <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_go) begin
                  x_l      <= x_in;
                  a_l      <= a_in;
                  r        <= '0;
                  c        <= '0;
                  k        <= '0;
                  max_run  <= '0;
                  ovf_flag <= 1'b0;
               end
            end
            S_MAC: begin
               if (mac_last) begin
                  sq_l[r][c] <= mac_elem;
                  ovf_flag   <= ovf_flag | mac_ovf;
                  k          <= '0;
                  if (c == 2'd2) begin
                     c <= '0;
                     r <= (r == 2'd2) ? 2'd0 : r + 2'd1;
                  end else begin
                     c <= c + 2'd1;
                  end
               end else begin
                  k <= k + 2'd1;
               end
            end
            S_CMP: begin
               max_run <= max_nx;
               if (c == 2'd2) begin
                  c <= '0;
                  r <= (r == 2'd2) ? 2'd0 : r + 2'd1;
               end else begin
                  c <= c + 2'd1;
               end
               if (cmp_end) begin
                  sq_out   <= sq_l;
                  o_maxerr <= max_nx;
                  o_pass   <= (max_nx <= ERR_W'(TOL));
                  o_ovf    <= ovf_flag;
                  o_Dval   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
